// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer, free list and branch stack.
package reorder_buffer_pkg;

   localparam int ROB_SIZE   = 32;
   localparam int ROB_PTR_W  = $clog2(ROB_SIZE);
   localparam int PHYS_REG_W = 6;

   typedef logic [PHYS_REG_W-1:0] phys_reg_t;
   typedef logic [ROB_PTR_W-1:0]  rob_ptr_t;
   // One extra bit so an occupancy of exactly ROB_SIZE is representable.
   typedef logic [ROB_PTR_W:0]    rob_cnt_t;

   localparam phys_reg_t PHYS_ZERO_REG = '0;
   localparam rob_cnt_t  ROB_FULL_CNT  = rob_cnt_t'(ROB_SIZE);

   // Retire count encoding doubles as the numeric count.
   typedef enum logic [1:0] {
      RET_NONE = 2'b00,
      RET_ONE  = 2'b01,
      RET_TWO  = 2'b10
   } ret_cnt_e;

   typedef struct packed {
      phys_reg_t tag;
      phys_reg_t tag_old;
      logic      done;
   } rob_entry_t;

   localparam rob_entry_t ENTRY_RESET = '{tag: PHYS_ZERO_REG, tag_old: PHYS_ZERO_REG, done: 1'b0};

   // In-order retire selection: the second slot may only retire behind the first.
   function automatic ret_cnt_e rob_retire_sel(input rob_cnt_t count,
                                               input logic     done_head,
                                               input logic     done_next);
      logic r0;
      logic r1;
      r0 = (count != '0) && done_head;
      r1 = r0 && (count >= rob_cnt_t'(2)) && done_next;
      if (r1)      return RET_TWO;
      else if (r0) return RET_ONE;
      else         return RET_NONE;
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 2-way dispatch / 2-way in-order retire reorder buffer with mispredict tail rollback.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic      [1:0]       haz_nDispatched,
   input  phys_reg_t [1:0]       disp_tag,
   input  phys_reg_t [1:0]       disp_tagOld,
   input  logic      [1:0]       cdb_valid,
   input  rob_ptr_t  [1:0]       cdb_robIdx,
   input  logic                  br_pred_wrong,
   input  rob_ptr_t              bs_recov_rob_tail,
   output rob_ptr_t  [1:0]       rob_dispIdx,
   output rob_ptr_t              rob_tail,
   output rob_cnt_t              rob_availableSlots,
   output phys_reg_t [1:0]       rob_retireTag,
   output phys_reg_t [1:0]       rob_retireTagOld,
   output logic      [1:0]       rob_nRetired
);

   rob_entry_t entries_q [ROB_SIZE];
   rob_entry_t entries_d [ROB_SIZE];
   rob_ptr_t   head_q, head_d;
   rob_ptr_t   tail_q, tail_d;
   rob_cnt_t   count_q, count_d;

   ret_cnt_e   ret_sel;
   logic [1:0] n_ret;
   rob_ptr_t   head_p1;
   rob_ptr_t   recov_span;

   // Retire selection and retire-port data, straight from registered state.
   always_comb begin
      head_p1             = head_q + rob_ptr_t'(1);
      ret_sel             = rob_retire_sel(count_q, entries_q[head_q].done, entries_q[head_p1].done);
      n_ret               = ret_sel;
      rob_nRetired        = n_ret;
      rob_retireTag[0]    = entries_q[head_q].tag;
      rob_retireTag[1]    = entries_q[head_p1].tag;
      rob_retireTagOld[0] = entries_q[head_q].tag_old;
      rob_retireTagOld[1] = entries_q[head_p1].tag_old;
      rob_dispIdx[0]      = tail_q;
      rob_dispIdx[1]      = tail_q + rob_ptr_t'(1);
      rob_tail            = tail_q;
      rob_availableSlots  = ROB_FULL_CNT - count_q;
   end

   // Pointer and occupancy update, including mispredict rollback of the tail.
   always_comb begin
      head_d     = head_q + rob_ptr_t'(n_ret);
      recov_span = bs_recov_rob_tail - head_d;
      if (br_pred_wrong) begin
         tail_d  = bs_recov_rob_tail;
         // Branch is still resident, so a zero span can only mean a full buffer.
         count_d = (recov_span == '0) ? ROB_FULL_CNT : {1'b0, recov_span};
      end else begin
         tail_d  = tail_q + rob_ptr_t'(haz_nDispatched);
         count_d = count_q + rob_cnt_t'(haz_nDispatched) - rob_cnt_t'(n_ret);
      end
   end

   // Entry array update: CDB sets done, then allocation overwrites (and clears done).
   always_comb begin
      // NOTE: combinational blocks take a full default copy first and use blocking
      // assignments, so every element has a value on every path and no latch forms.
      entries_d = entries_q;
      for (int l = 0; l < 2; l++) begin
         if (cdb_valid[l]) entries_d[cdb_robIdx[l]].done = 1'b1;
      end
      if (!br_pred_wrong) begin
         for (int s = 0; s < 2; s++) begin
            if (2'(s) < haz_nDispatched) begin
               entries_d[tail_q + rob_ptr_t'(s)] = '{tag: disp_tag[s], tag_old: disp_tagOld[s], done: 1'b0};
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         // NOTE: the entry array is reset because the retire ports always drive
         // entry contents and must read as zero after reset.
         for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= ENTRY_RESET;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= entries_d[i];
      end
   end

   // Hazard unit must never over-dispatch.
   a_disp_legal : assert property (@(posedge clk) disable iff (!reset)
      !br_pred_wrong |-> (haz_nDispatched != 2'b11) &&
                         (rob_cnt_t'(haz_nDispatched) <= rob_availableSlots));

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic      [1:0]      haz_nDispatched;
   phys_reg_t [1:0]      disp_tag;
   phys_reg_t [1:0]      disp_tagOld;
   logic      [1:0]      cdb_valid;
   rob_ptr_t  [1:0]      cdb_robIdx;
   logic                 br_pred_wrong;
   rob_ptr_t             bs_recov_rob_tail;
   rob_ptr_t  [1:0]      rob_dispIdx;
   rob_ptr_t             rob_tail;
   rob_cnt_t             rob_availableSlots;
   phys_reg_t [1:0]      rob_retireTag;
   phys_reg_t [1:0]      rob_retireTagOld;
   logic      [1:0]      rob_nRetired;

   int n_checks = 0;
   int n_fail   = 0;

   reorder_buffer dut (
      .clk                (clk),
      .reset              (reset),
      .haz_nDispatched    (haz_nDispatched),
      .disp_tag           (disp_tag),
      .disp_tagOld        (disp_tagOld),
      .cdb_valid          (cdb_valid),
      .cdb_robIdx         (cdb_robIdx),
      .br_pred_wrong      (br_pred_wrong),
      .bs_recov_rob_tail  (bs_recov_rob_tail),
      .rob_dispIdx        (rob_dispIdx),
      .rob_tail           (rob_tail),
      .rob_availableSlots (rob_availableSlots),
      .rob_retireTag      (rob_retireTag),
      .rob_retireTagOld   (rob_retireTagOld),
      .rob_nRetired       (rob_nRetired)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      haz_nDispatched   = 2'd0;
      disp_tag          = '0;
      disp_tagOld       = '0;
      cdb_valid         = 2'b00;
      cdb_robIdx        = '0;
      br_pred_wrong     = 1'b0;
      bs_recov_rob_tail = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (rob_availableSlots !== 6'd32) begin n_fail++; $display("FAIL reset_avail: got %0d want 32", rob_availableSlots); end
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL reset_nret: got %0d want 0", rob_nRetired); end
      n_checks++; if (rob_tail !== 5'd0) begin n_fail++; $display("FAIL reset_tail: got %0d want 0", rob_tail); end
      n_checks++; if (rob_dispIdx !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL reset_dispidx: got %h want %h", rob_dispIdx, {5'd1, 5'd0}); end
   endtask

   task automatic test_ooo_completion();
      haz_nDispatched = 2'd2;
      disp_tag[0] = 6'd32; disp_tag[1] = 6'd33;
      disp_tagOld[0] = 6'd1; disp_tagOld[1] = 6'd2;
      cycle();
      idle();
      cdb_valid = 2'b10; cdb_robIdx[1] = 5'd1;
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL ooo_nret_before: got %0d want 0", rob_nRetired); end
      cycle();
      idle();
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL ooo_nret_e1_only: got %0d want 0", rob_nRetired); end
      cdb_valid = 2'b01; cdb_robIdx[0] = 5'd0;
      cycle();
      idle();
      n_checks++; if (rob_nRetired !== 2'b10) begin n_fail++; $display("FAIL ooo_nret_two: got %0d want 2", rob_nRetired); end
      n_checks++; if (rob_retireTag !== {6'd33, 6'd32}) begin n_fail++; $display("FAIL ooo_tag: got %h want %h", rob_retireTag, {6'd33, 6'd32}); end
      n_checks++; if (rob_retireTagOld !== {6'd2, 6'd1}) begin n_fail++; $display("FAIL ooo_tagold: got %h want %h", rob_retireTagOld, {6'd2, 6'd1}); end
      cycle();
      n_checks++; if (rob_availableSlots !== 6'd32) begin n_fail++; $display("FAIL ooo_avail_after: got %0d want 32", rob_availableSlots); end
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL ooo_nret_after: got %0d want 0", rob_nRetired); end
   endtask

   task automatic test_full();
      do_reset();
      for (int j = 0; j < 16; j++) begin
         haz_nDispatched = 2'd2;
         disp_tag[0] = phys_reg_t'(32 + 2*j);  disp_tag[1] = phys_reg_t'(33 + 2*j);
         disp_tagOld[0] = phys_reg_t'(2*j);    disp_tagOld[1] = phys_reg_t'(2*j + 1);
         cycle();
      end
      idle();
      n_checks++; if (rob_availableSlots !== 6'd0) begin n_fail++; $display("FAIL full_avail: got %0d want 0", rob_availableSlots); end
      n_checks++; if (rob_tail !== 5'd0) begin n_fail++; $display("FAIL full_tail: got %0d want 0", rob_tail); end
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL full_nret: got %0d want 0", rob_nRetired); end
      cdb_valid = 2'b01; cdb_robIdx[0] = 5'd0;
      cycle();
      idle();
      n_checks++; if (rob_nRetired !== 2'b01) begin n_fail++; $display("FAIL full_nret_one: got %0d want 1", rob_nRetired); end
      n_checks++; if (rob_retireTag[0] !== 6'd32) begin n_fail++; $display("FAIL full_tag0: got %0d want 32", rob_retireTag[0]); end
      n_checks++; if (rob_retireTagOld[0] !== 6'd0) begin n_fail++; $display("FAIL full_tagold0: got %0d want 0", rob_retireTagOld[0]); end
      cycle();
      n_checks++; if (rob_availableSlots !== 6'd1) begin n_fail++; $display("FAIL full_avail_after: got %0d want 1", rob_availableSlots); end
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL full_nret_after: got %0d want 0", rob_nRetired); end
   endtask

   task automatic test_wrap();
      int waited;
      do_reset();
      for (int j = 0; j < 15; j++) begin
         haz_nDispatched = 2'd2;
         disp_tag[0] = phys_reg_t'(2*j); disp_tag[1] = phys_reg_t'(2*j + 1);
         cycle();
      end
      idle();
      for (int j = 0; j < 15; j++) begin
         cdb_valid = 2'b11;
         cdb_robIdx[0] = rob_ptr_t'(2*j); cdb_robIdx[1] = rob_ptr_t'(2*j + 1);
         cycle();
      end
      idle();
      waited = 0;
      while (rob_availableSlots != 6'd32 && waited < 40) begin
         cycle();
         waited++;
      end
      n_checks++; if (rob_availableSlots !== 6'd32) begin n_fail++; $display("FAIL wrap_drain: got %0d want 32 (timeout)", rob_availableSlots); end
      n_checks++; if (rob_tail !== 5'd30) begin n_fail++; $display("FAIL wrap_tail30: got %0d want 30", rob_tail); end

      haz_nDispatched = 2'd2;
      disp_tag[0] = 6'd40; disp_tag[1] = 6'd41; disp_tagOld[0] = 6'd20; disp_tagOld[1] = 6'd21;
      n_checks++; if (rob_dispIdx !== {5'd31, 5'd30}) begin n_fail++; $display("FAIL wrap_idx_a: got %h want %h", rob_dispIdx, {5'd31, 5'd30}); end
      cycle();
      disp_tag[0] = 6'd42; disp_tag[1] = 6'd43; disp_tagOld[0] = 6'd22; disp_tagOld[1] = 6'd23;
      n_checks++; if (rob_dispIdx !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL wrap_idx_b: got %h want %h", rob_dispIdx, {5'd1, 5'd0}); end
      cycle();
      disp_tag[0] = 6'd44; disp_tag[1] = 6'd45; disp_tagOld[0] = 6'd24; disp_tagOld[1] = 6'd25;
      n_checks++; if (rob_dispIdx !== {5'd3, 5'd2}) begin n_fail++; $display("FAIL wrap_idx_c: got %h want %h", rob_dispIdx, {5'd3, 5'd2}); end
      cycle();
      idle();
      n_checks++; if (rob_tail !== 5'd4) begin n_fail++; $display("FAIL wrap_tail4: got %0d want 4", rob_tail); end
      n_checks++; if (rob_availableSlots !== 6'd26) begin n_fail++; $display("FAIL wrap_avail26: got %0d want 26", rob_availableSlots); end

      cdb_valid = 2'b11; cdb_robIdx[0] = 5'd30; cdb_robIdx[1] = 5'd31;
      cycle();
      n_checks++; if (rob_nRetired !== 2'b10) begin n_fail++; $display("FAIL wrap_nret_a: got %0d want 2", rob_nRetired); end
      n_checks++; if (rob_retireTag !== {6'd41, 6'd40}) begin n_fail++; $display("FAIL wrap_tag_a: got %h want %h", rob_retireTag, {6'd41, 6'd40}); end
      n_checks++; if (rob_retireTagOld !== {6'd21, 6'd20}) begin n_fail++; $display("FAIL wrap_old_a: got %h want %h", rob_retireTagOld, {6'd21, 6'd20}); end
      cdb_robIdx[0] = 5'd0; cdb_robIdx[1] = 5'd1;
      cycle();
      n_checks++; if (rob_retireTag !== {6'd43, 6'd42} || rob_nRetired !== 2'b10) begin n_fail++; $display("FAIL wrap_tag_b: got %h/%0d want %h/2", rob_retireTag, rob_nRetired, {6'd43, 6'd42}); end
      cdb_robIdx[0] = 5'd2; cdb_robIdx[1] = 5'd3;
      cycle();
      idle();
      n_checks++; if (rob_retireTag !== {6'd45, 6'd44} || rob_nRetired !== 2'b10) begin n_fail++; $display("FAIL wrap_tag_c: got %h/%0d want %h/2", rob_retireTag, rob_nRetired, {6'd45, 6'd44}); end
      cycle();
      n_checks++; if (rob_availableSlots !== 6'd32 || rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL wrap_empty: got avail %0d nret %0d want 32/0", rob_availableSlots, rob_nRetired); end
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int j = 0; j < 5; j++) begin
         haz_nDispatched = 2'd2;
         disp_tag[0] = phys_reg_t'(50 + 2*j); disp_tag[1] = phys_reg_t'(51 + 2*j);
         cycle();
      end
      idle();
      cdb_valid = 2'b11; cdb_robIdx[0] = 5'd5; cdb_robIdx[1] = 5'd6;
      cycle();
      cdb_robIdx[0] = 5'd0; cdb_robIdx[1] = 5'd1;
      cycle();
      idle();
      n_checks++; if (rob_nRetired !== 2'b10 || rob_retireTag !== {6'd51, 6'd50}) begin n_fail++; $display("FAIL mp_pre_retire: got %0d/%h want 2/%h", rob_nRetired, rob_retireTag, {6'd51, 6'd50}); end
      br_pred_wrong = 1'b1; bs_recov_rob_tail = 5'd5;
      haz_nDispatched = 2'd2; disp_tag[0] = 6'd60; disp_tag[1] = 6'd61;
      cdb_valid = 2'b01; cdb_robIdx[0] = 5'd7;
      cycle();
      idle();
      n_checks++; if (rob_tail !== 5'd5) begin n_fail++; $display("FAIL mp_tail: got %0d want 5", rob_tail); end
      n_checks++; if (rob_availableSlots !== 6'd29) begin n_fail++; $display("FAIL mp_avail: got %0d want 29", rob_availableSlots); end
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL mp_nret: got %0d want 0", rob_nRetired); end
      haz_nDispatched = 2'd1; disp_tag[0] = 6'd7; disp_tagOld[0] = 6'd8;
      n_checks++; if (rob_dispIdx[0] !== 5'd5) begin n_fail++; $display("FAIL mp_redisp_idx: got %0d want 5", rob_dispIdx[0]); end
      cycle();
      idle();
      cdb_valid = 2'b11; cdb_robIdx[0] = 5'd2; cdb_robIdx[1] = 5'd3;
      cycle();
      idle();
      cdb_valid = 2'b01; cdb_robIdx[0] = 5'd4;
      n_checks++; if (rob_nRetired !== 2'b10 || rob_retireTag !== {6'd53, 6'd52}) begin n_fail++; $display("FAIL mp_head2: got %0d/%h want 2/%h", rob_nRetired, rob_retireTag, {6'd53, 6'd52}); end
      cycle();
      idle();
      n_checks++; if (rob_nRetired !== 2'b01) begin n_fail++; $display("FAIL mp_done_cleared: got %0d want 1", rob_nRetired); end
      n_checks++; if (rob_retireTag !== {6'd7, 6'd54}) begin n_fail++; $display("FAIL mp_tags45: got %h want %h", rob_retireTag, {6'd7, 6'd54}); end
      cycle();
      n_checks++; if (rob_nRetired !== 2'b00 || rob_retireTag[0] !== 6'd7 || rob_retireTagOld[0] !== 6'd8) begin n_fail++; $display("FAIL mp_entry5: got %0d/%0d/%0d want 0/7/8", rob_nRetired, rob_retireTag[0], rob_retireTagOld[0]); end
      n_checks++; if (rob_availableSlots !== 6'd31) begin n_fail++; $display("FAIL mp_avail_end: got %0d want 31", rob_availableSlots); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int j = 0; j < 3; j++) begin
         haz_nDispatched = 2'd2;
         disp_tag[0] = phys_reg_t'(10 + 2*j); disp_tag[1] = phys_reg_t'(11 + 2*j);
         cycle();
      end
      idle();
      cdb_valid = 2'b11; cdb_robIdx[0] = 5'd0; cdb_robIdx[1] = 5'd1;
      cycle();
      cdb_robIdx[0] = 5'd2; cdb_robIdx[1] = 5'd3;
      cycle();
      idle();
      n_checks++; if (rob_nRetired !== 2'b10) begin n_fail++; $display("FAIL ar_active: got %0d want 2", rob_nRetired); end
      #3;
      reset = 1'b0;
      #1;
      n_checks++; if (rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL ar_nret_now: got %0d want 0", rob_nRetired); end
      n_checks++; if (rob_availableSlots !== 6'd32) begin n_fail++; $display("FAIL ar_avail_now: got %0d want 32", rob_availableSlots); end
      @(posedge clk); #1;
      cycle();
      cycle();
      n_checks++; if (rob_availableSlots !== 6'd32 || rob_tail !== 5'd0 || rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL ar_hold: got avail %0d tail %0d nret %0d want 32/0/0", rob_availableSlots, rob_tail, rob_nRetired); end
      reset = 1'b1;
      n_checks++; if (rob_dispIdx !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL ar_release_idx: got %h want %h", rob_dispIdx, {5'd1, 5'd0}); end
      haz_nDispatched = 2'd1; disp_tag[0] = 6'd9;
      cycle();
      idle();
      n_checks++; if (rob_availableSlots !== 6'd31 || rob_nRetired !== 2'b00) begin n_fail++; $display("FAIL ar_after: got avail %0d nret %0d want 31/0", rob_availableSlots, rob_nRetired); end
   endtask

   initial begin
      idle();
      test_reset();
      test_ooo_completion();
      test_full();
      test_wrap();
      test_mispredict();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
